// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Program sequencer placed in front of the control unit. It holds a small
// loadable program memory and maintains the program counter. It presents one
// 16-bit instruction at a time together with a valid flag. HALT (4'hF) is
// executed locally. JMP (4'h8) is also executed locally when
// INSTR_FETCH_BRANCH_EN is defined. All other opcodes pass through unchanged.
//
// Compile-time option:
//   INSTR_FETCH_BRANCH_EN  defined     -> JMP loads pc from instruction[ADDR_W-1:0]
//                          not defined -> 4'h8 is an ordinary instruction
//
// Parameters:
//   ADDR_W  program counter / memory address width
//   DEPTH   program memory words; must equal 2**ADDR_W so pc wraps naturally
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin execution at address 0 (IDLE/HALTED only)
//   stall        in   downstream hold, sampled in ISSUE only
//   prog_we      in   program memory write strobe (IDLE/HALTED only)
//   prog_addr    in   program memory write address
//   prog_data    in   program memory write data
//   instruction  out  instruction to control unit, 16'hF000 when not valid
//   instr_valid  out  instruction is live this cycle
//   pc           out  address of the current or next fetch
//   busy         out  high in FETCH and ISSUE
//   halted       out  high in HALTED
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | after reset, waiting for start; program loading allowed
// FETCH  | synchronous memory read at pc into the instruction register
// ISSUE  | instruction presented with instr_valid=1; held while stall
// HALTED | HALT issued, pc points at the HALT word; loading/start allowed
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [15:0] NOP_WORD = 16'hF000;
    localparam logic [3:0]  OP_HALT  = 4'b1111;
`ifdef INSTR_FETCH_BRANCH_EN
    localparam logic [3:0]  OP_JMP   = 4'b1000;
`endif

    state_t      state;
    logic [15:0] mem [DEPTH];
    logic        load_ok;

    // Loading is only allowed while the sequencer is not running. This keeps
    // the program stable under an executing fetch.
    assign load_ok = (state == IDLE) || (state == HALTED);

    // The memory has no reset, so the program survives rst_n pulses.
    always_ff @(posedge clk) begin
        if (prog_we && load_ok) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end

                FETCH: begin
                    // A write issued together with start has already landed,
                    // so the word at address 0 is current here.
                    instruction <= mem[pc];
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
                end

                ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        instruction <= NOP_WORD;
                        if (instruction[15:12] == OP_HALT) begin
                            busy   <= 1'b0;
                            halted <= 1'b1;
                            state  <= HALTED;
                        end
`ifdef INSTR_FETCH_BRANCH_EN
                        else if (instruction[15:12] == OP_JMP) begin
                            pc    <= instruction[ADDR_W-1:0];
                            state <= FETCH;
                        end
                        else begin
                            pc    <= pc + 1'b1;
                            state <= FETCH;
                        end
`else
                        else begin
                            pc    <= pc + 1'b1;
                            state <= FETCH;
                        end
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        if (!instr_valid) chk("wait_valid", {31'b0, instr_valid}, 32'd1);
    endtask

    // Waits for the next issue, checks the word and pc, then moves past it.
    task automatic expect_issue(input string tag, input logic [15:0] exp_instr,
                                input logic [7:0] exp_pc);
        wait_valid(6);
        chk({tag, "_instr"}, {16'b0, instruction}, {16'b0, exp_instr});
        chk({tag, "_pc"}, {24'b0, pc}, {24'b0, exp_pc});
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        #12;
        chk("rst_instr",  {16'b0, instruction}, 32'hF000);
        chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
        chk("rst_pc",     {24'b0, pc}, 32'd0);
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        rst_n = 1'b1;

        // Basic program with a stall and an ignored write during execution.
        load_word(8'd0, 16'h0000);
        load_word(8'd1, 16'h1000);
        load_word(8'd2, 16'h6003);
        load_word(8'd3, 16'hF000);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s_fetch_busy",  {31'b0, busy}, 32'd1);
        chk("s_fetch_valid", {31'b0, instr_valid}, 32'd0);
        stall = 1'b1;                       // stall during FETCH has no effect
        tick();
        stall = 1'b0;
        chk("i0_valid", {31'b0, instr_valid}, 32'd1);
        chk("i0_instr", {16'b0, instruction}, 32'h0000);
        tick();
        chk("f1_valid", {31'b0, instr_valid}, 32'd0);
        chk("f1_instr", {16'b0, instruction}, 32'hF000);
        chk("f1_pc",    {24'b0, pc}, 32'd1);
        prog_we = 1'b1; prog_addr = 8'd3; prog_data = 16'h0000;   // must be ignored
        tick();
        prog_we = 1'b0;
        chk("i1_instr", {16'b0, instruction}, 32'h1000);
        start = 1'b1;                       // start while busy is ignored
        tick();
        start = 1'b0;
        chk("f2_pc",    {24'b0, pc}, 32'd2);
        tick();
        chk("i2_instr", {16'b0, instruction}, 32'h6003);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", {16'b0, instruction}, 32'h6003);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc",    {24'b0, pc}, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("f3_pc", {24'b0, pc}, 32'd3);
        tick();
        chk("i3_instr", {16'b0, instruction}, 32'hF000);
        chk("i3_valid", {31'b0, instr_valid}, 32'd1);
        tick();
        chk("h_halted", {31'b0, halted}, 32'd1);
        chk("h_pc",     {24'b0, pc}, 32'd3);
        chk("h_busy",   {31'b0, busy}, 32'd0);
        chk("h_valid",  {31'b0, instr_valid}, 32'd0);

        // Jump program; address 0 is written in the same cycle as start.
        load_word(8'd1, 16'h8005);
        load_word(8'd5, 16'hF000);
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h0001; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        chk("b_busy", {31'b0, busy}, 32'd1);
        expect_issue("b0", 16'h0001, 8'd0);
        expect_issue("b1", 16'h8005, 8'd1);
`ifdef INSTR_FETCH_BRANCH_EN
        expect_issue("b2", 16'hF000, 8'd5);
        chk("b_halted", {31'b0, halted}, 32'd1);
        chk("b_pc",     {24'b0, pc}, 32'd5);
`else
        expect_issue("b2", 16'h6003, 8'd2);
        expect_issue("b3", 16'hF000, 8'd3);
        chk("b_halted", {31'b0, halted}, 32'd1);
        chk("b_pc",     {24'b0, pc}, 32'd3);
`endif

        // Wrap: all-zero memory runs through 255 and back to 0.
        for (int i = 0; i < 256; i++) load_word(8'(i), 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(instr_valid && pc == 8'd255) && n < 1200) begin
            tick();
            n++;
        end
        chk("w_reach255", {24'b0, pc}, 32'd255);
        chk("w_instr255", {16'b0, instruction}, 32'h0000);
        tick();
        chk("w_wrap_pc", {24'b0, pc}, 32'd0);
        expect_issue("w0", 16'h0000, 8'd0);
        wait_valid(6);
        chk("w1_pc", {24'b0, pc}, 32'd1);

        // Asynchronous reset mid-ISSUE.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid",  {31'b0, instr_valid}, 32'd0);
        chk("ar_instr",  {16'b0, instruction}, 32'hF000);
        chk("ar_pc",     {24'b0, pc}, 32'd0);
        chk("ar_busy",   {31'b0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Re-run retained program with a HALT placed at address 2.
        load_word(8'd2, 16'hF000);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_issue("r0", 16'h0000, 8'd0);
        expect_issue("r1", 16'h0000, 8'd1);
        expect_issue("r2", 16'hF000, 8'd2);
        chk("r_halted", {31'b0, halted}, 32'd1);
        chk("r_pc",     {24'b0, pc}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
